// File: rtl/pool_frame_buffer_if.sv
// rtl/pool_frame_buffer_if.sv - pixel-in / frame-out handshake bundle for pool_frame_buffer
//
// Ports (signals):
//   pix_in, pix_valid, pix_sof   raster pixel stream toward the buffer
//   pix_ready                    buffer can take a pixel this cycle
//   frame_out_flat, frame_valid  assembled frame toward avg_pool2d
//   frame_ready                  consumer takes the frame this cycle
//   sof_err                      one-cycle pulse when a partial frame is dropped
// Modports: master = pixel producer / frame consumer side, slave = buffer side.
interface pool_frame_buffer_if #(
  parameter int IN_SIZE   = 4,
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0]                   pix_in;
  logic                                   pix_valid;
  logic                                   pix_sof;
  logic                                   pix_ready;
  logic [IN_SIZE*IN_SIZE*BIT_WIDTH-1:0]   frame_out_flat;
  logic                                   frame_valid;
  logic                                   frame_ready;
  logic                                   sof_err;

  modport master (
    output pix_in, pix_valid, pix_sof, frame_ready,
    input  pix_ready, frame_out_flat, frame_valid, sof_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, frame_ready,
    output pix_ready, frame_out_flat, frame_valid, sof_err
  );
endinterface

// File: rtl/pool_frame_buffer.sv
// rtl/pool_frame_buffer.sv - ping-pong raster-to-frame assembler feeding avg_pool2d
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears banks, pointers and flags
//   bus  pool_frame_buffer_if.slave
//        pixel side : pix_in/pix_valid/pix_sof in, pix_ready out
//        frame side : frame_out_flat/frame_valid/sof_err out, frame_ready in
// Pixel k of a frame lands at bits [(N-k)*BIT_WIDTH-1 : (N-k-1)*BIT_WIDTH],
// so pixel 0 sits at the MSB of frame_out_flat.
module pool_frame_buffer #(
  parameter int IN_SIZE   = 4,
  parameter int BIT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  pool_frame_buffer_if.slave bus
);
  localparam int N  = IN_SIZE * IN_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N*BIT_WIDTH-1:0] bank [2];
  logic                   wr_bank;
  logic                   rd_bank;
  logic [1:0]             full;
  logic [CW-1:0]          cnt;
  logic                   sof_err_q;

  logic                   accept;
  logic                   consume;
  logic                   restart;
  logic                   last;
  logic [CW-1:0]          wr_pos;

  assign accept  = bus.pix_valid && bus.pix_ready;
  assign consume = full[rd_bank] && bus.frame_ready;
  // A start-of-frame mid-frame wins over count completion: the pixel
  // restarts the frame at position 0 instead of finishing the old one.
  assign restart = bus.pix_sof && (cnt != '0);
  assign last    = !restart && (cnt == CW'(N - 1));
  assign wr_pos  = restart ? '0 : cnt;

  assign bus.pix_ready      = !rst && !full[wr_bank];
  assign bus.frame_valid    = full[rd_bank];
  assign bus.frame_out_flat = bank[rd_bank];
  assign bus.sof_err        = sof_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0]   <= '0;
      bank[1]   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      cnt       <= '0;
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= accept && restart;

      // Consume and complete can coincide; they always target different
      // banks because completing needs the write bank empty while consuming
      // needs the read bank full.
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end

      if (accept) begin
        bank[wr_bank][(N - 1 - int'(wr_pos)) * BIT_WIDTH +: BIT_WIDTH] <= bus.pix_in;
        if (restart) begin
          cnt <= CW'(1);
        end else if (last) begin
          cnt           <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_frame_buffer.sv
// tb/tb_pool_frame_buffer.sv - self-checking bench for pool_frame_buffer
module tb_pool_frame_buffer;
  localparam int IN_SIZE   = 4;
  localparam int BIT_WIDTH = 8;
  localparam int N         = IN_SIZE * IN_SIZE;
  localparam int W         = N * BIT_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pool_frame_buffer_if #(.IN_SIZE(IN_SIZE), .BIT_WIDTH(BIT_WIDTH)) pif ();

  pool_frame_buffer #(.IN_SIZE(IN_SIZE), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  // Reference model: pixels of the frame in progress, and completed frames
  // waiting to be taken (oldest first). At most two frames can wait.
  logic [BIT_WIDTH-1:0] cur_q [$];
  logic [W-1:0]         exp_q [$];
  bit                   exp_err;
  bit                   cleared;
  int                   consumed;
  int                   n_checks;
  int                   n_err;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_seq(input int base, input int inc);
    logic [W-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[(N-1-k)*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(base + k*inc);
    return f;
  endfunction

  task automatic model_pix(input logic [BIT_WIDTH-1:0] p, input bit sof);
    logic [W-1:0] f;
    if (sof && cur_q.size() != 0) begin
      cur_q.delete();
      exp_err = 1'b1;
    end
    cur_q.push_back(p);
    if (cur_q.size() == N) begin
      f = '0;
      for (int k = 0; k < N; k++) f[(N-1-k)*BIT_WIDTH +: BIT_WIDTH] = cur_q[k];
      exp_q.push_back(f);
      cur_q.delete();
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the
  // model with whatever the model says happens at the edge.
  task automatic step(output bit acc);
    bit                   con;
    bit                   exp_ready;
    logic [BIT_WIDTH-1:0] p;
    bit                   s;
    @(negedge clk);
    exp_ready = !rst && (exp_q.size() < 2);
    check("pix_ready", W'(pif.pix_ready), W'(exp_ready));
    check("frame_valid", W'(pif.frame_valid), W'(exp_q.size() != 0));
    check("sof_err", W'(pif.sof_err), W'(exp_err));
    if (exp_q.size() != 0) check("frame_out", pif.frame_out_flat, exp_q[0]);
    else if (cleared) check("frame_out_reset", pif.frame_out_flat, '0);
    acc = pif.pix_valid && exp_ready;
    con = (exp_q.size() != 0) && pif.frame_ready;
    p   = pif.pix_in;
    s   = pif.pix_sof;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    cleared = rst;
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
      acc = 1'b0;
    end else begin
      if (con) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      if (acc) model_pix(p, s);
    end
  endtask

  task automatic push(input logic [BIT_WIDTH-1:0] p, input bit sof);
    bit a;
    int t;
    pif.pix_in    = p;
    pif.pix_valid = 1'b1;
    pif.pix_sof   = sof;
    a = 1'b0;
    t = 0;
    while (!a && t < 200) begin
      step(a);
      t++;
    end
    if (!a) check("push_timeout", W'(a), W'(1));
    pif.pix_valid = 1'b0;
    pif.pix_sof   = 1'b0;
  endtask

  task automatic push_frame(input int base, input int inc);
    for (int k = 0; k < N; k++) push(BIT_WIDTH'(base + k*inc), k == 0);
  endtask

  task automatic drain();
    bit a;
    int t;
    pif.pix_valid   = 1'b0;
    pif.frame_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      step(a);
      t++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    pif.frame_ready = 1'b0;
  endtask

  initial begin
    bit           a;
    int           c;
    int           t;
    logic [W-1:0] o;

    n_checks = 0; n_err = 0; consumed = 0; exp_err = 0; cleared = 0;
    pif.pix_in = '0; pif.pix_valid = 1'b0; pif.pix_sof = 1'b0; pif.frame_ready = 1'b0;

    // Reset: take two edges, then check the cleared state while still in reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cleared = 1'b1;
    step(a);
    step(a);
    rst = 1'b0;

    // Frame 4,8,...,64 with a willing consumer.
    pif.frame_ready = 1'b1;
    for (int k = 0; k < N; k++) push(BIT_WIDTH'(4*(k+1)), k == 0);
    check("t1_valid", W'(pif.frame_valid), W'(1));
    check("t1_frame", pif.frame_out_flat, 128'h04080C10_14181C20_24282C30_34383C40);
    drain();

    // Three frames against a stalled consumer.
    pif.frame_ready = 1'b0;
    for (int k = 0; k < 2*N; k++) push(BIT_WIDTH'(k+1), (k % N) == 0);
    pif.pix_in = 8'd33; pif.pix_valid = 1'b1; pif.pix_sof = 1'b1;
    for (int i = 0; i < 3; i++) step(a);
    check("t2_stall_ready", W'(pif.pix_ready), W'(0));
    check("t2_held", pif.frame_out_flat, pack_seq(1, 1));
    pif.frame_ready = 1'b1;
    step(a);
    pif.frame_ready = 1'b0;
    check("t2_frame2", pif.frame_out_flat, pack_seq(17, 1));
    check("t2_ready_back", W'(pif.pix_ready), W'(1));
    for (int k = 0; k < N; k++) push(BIT_WIDTH'(33+k), k == 0);
    drain();

    // Start-of-frame after 5 pixels discards them.
    pif.frame_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(BIT_WIDTH'(8'h50 + k), k == 0);
    push(8'hAA, 1'b1);
    check("t3_sof_err", W'(pif.sof_err), W'(1));
    for (int k = 1; k < N; k++) push(BIT_WIDTH'(8'hB0 + k), 1'b0);
    o = pif.frame_out_flat;
    check("t3_first_pix", W'(o[W-1 -: BIT_WIDTH]), W'(8'hAA));
    drain();

    // Reset with one frame pending and 9 pixels of the next in flight.
    pif.frame_ready = 1'b0;
    push_frame(8'h60, 1);
    for (int k = 0; k < 9; k++) push(BIT_WIDTH'(8'h70 + k), k == 0);
    rst = 1'b1;
    step(a);
    step(a);
    check("t4_rst_out", pif.frame_out_flat, '0);
    check("t4_rst_ready", W'(pif.pix_ready), W'(0));
    rst = 1'b0;
    push_frame(8'hC0, 1);
    drain();

    // Completing frame B in the same cycle frame A is taken.
    pif.frame_ready = 1'b0;
    push_frame(8'h10, 2);
    for (int k = 0; k < N-1; k++) push(BIT_WIDTH'(8'h80 + k), k == 0);
    pif.frame_ready = 1'b1;
    push(BIT_WIDTH'(8'h80 + N - 1), 1'b0);
    check("t6_no_bubble", W'(pif.frame_valid), W'(1));
    check("t6_frame_b", pif.frame_out_flat, pack_seq(8'h80, 1));
    drain();

    // Random valid / ready, 50 frames of incrementing data.
    c = 0;
    t = 0;
    while (c < 50*N && t < 20000) begin
      pif.pix_valid   = 1'($urandom_range(0, 1));
      pif.pix_in      = BIT_WIDTH'(c);
      pif.pix_sof     = (c % N) == 0;
      pif.frame_ready = 1'($urandom_range(0, 1));
      step(a);
      if (a) c++;
      t++;
    end
    check("t5_all_accepted", W'(c), W'(50*N));
    drain();

    check("frames_consumed", W'(consumed), W'(58));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pool_frame_buffer.md
Name: pool_frame_buffer

Overview:
- Upstream feeder for avg_pool2d.
- Accepts a raster stream of pixels, one per cycle, over a valid/ready handshake.
- Assembles each IN_SIZE x IN_SIZE frame into the row-major flat vector that avg_pool2d consumes on data_in_flat.
- Ping-pong (two-bank) buffering: the next frame fills while the previous one is held stable for the pooling stage.

Parameters:
- IN_SIZE, 4, frame edge length in pixels (frame = IN_SIZE*IN_SIZE pixels, N below).
- BIT_WIDTH, 8, bits per pixel.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  BIT_WIDTH  incoming pixel, raster order.
- pix_valid  input  1  pix_in valid this cycle.
- pix_sof  input  1  start-of-frame marker; meaningful only when pix_valid=1.
- pix_ready  output  1  block can accept a pixel this cycle.
- frame_out_flat  output  IN_SIZE*IN_SIZE*BIT_WIDTH  assembled frame; connects to avg_pool2d data_in_flat.
- frame_valid  output  1  frame_out_flat holds a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- sof_err  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Packing: pixel k of a frame (k = 0..N-1, row-major) occupies bits [(N-k)*BIT_WIDTH-1 : (N-k-1)*BIT_WIDTH]. Pixel 0 is at the MSB.
- State:
  - two banks of N pixels each;
  - wr_bank and rd_bank pointers (1 bit each);
  - full[1:0] flags;
  - fill counter cnt, range 0..N-1.
- Reset (rst=1 at an edge):
  - cnt=0, wr_bank=rd_bank=0, full=0, both banks cleared to 0;
  - frame_valid=0, frame_out_flat=0, sof_err=0;
  - pix_ready is forced to 0 while rst is high.
  - Reset mid-frame or with a frame pending discards everything; no frame is emitted.
- pix_ready = !rst && !full[wr_bank] (combinational).
- Pixel accept: pix_valid && pix_ready.
  - The pixel is written to bank[wr_bank] at position cnt, and cnt increments.
  - When cnt==N-1: set full[wr_bank], toggle wr_bank, cnt returns to 0.
- pix_sof handling on an accepted pixel:
  - cnt==0: normal, no error.
  - cnt!=0: the partial frame is discarded, the pixel is written at position 0, cnt=1, and sof_err pulses high for the next cycle.
  - pix_sof is not required. Frames are also delimited purely by count.
- Output side:
  - frame_valid = full[rd_bank] (registered state); frame_out_flat = bank[rd_bank].
  - On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank.
  - frame_out_flat is stable for as long as frame_valid=1 and frame_ready=0.
  - frame_out_flat value is don't-care while frame_valid=0.
- Latency: last pixel of a frame accepted at edge T -> frame_valid=1 after edge T, provided that bank is the rd_bank.
- Throughput: one pixel per cycle sustained, as long as the consumer takes each frame within N cycles.
- Both banks full: pix_ready=0, so stall upstream. Freeing a bank via frame_ready at edge T makes pix_ready=1 after T.
- Simultaneous events:
  - Consuming from one bank and completing the other bank in the same cycle is legal; both take effect.
  - The freed bank becomes the write target only when wr_bank points to it.
- No arithmetic. cnt width is clog2(N).

Test Plan:
- Reset, then stream pixels 4,8,12,...,64 (16 pixels, pix_sof on the first) with frame_ready=1 → frame_valid high the cycle after the 16th accept; frame_out_flat = 128'h04080C10_14181C20_24282C30_34383C40; avg_pool2d downstream then gives 14,22,46,54.
- frame_ready=0, stream 3 frames back-to-back (values 1..16, 17..32, 33..48) → after 32 accepts pix_ready=0 and frame 1 is held unchanged. Raise frame_ready for one cycle → frame 2 is presented and pix_ready=1. Frame 3 completes correctly.
- Stream 5 pixels, then pix_sof with pixel 0xAA → sof_err pulses once; the resulting frame begins 0xAA in bits [127:120]; the 5 stale pixels are absent.
- Assert rst after 9 pixels of a frame and with one frame pending → frame_valid=0, frame_out_flat=0, pix_ready=0 during reset. After release a fresh 16-pixel frame emerges intact.
- pix_valid toggled randomly, frame_ready random, 50 frames of incrementing data → every emitted frame matches the model in order; no drop or duplication.
- Last pixel of frame B accepted in the same cycle frame A is consumed → frame_valid stays 1 across the edge, and frame_out_flat switches to B with no bubble.
